// File: rtl/spi_sram_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_sram_responder_pkg
// Purpose : Shared opcodes, field widths and FSM state encoding for the
//           SPI serial-SRAM responder.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package spi_sram_responder_pkg;

  localparam logic [7:0] CMD_READ     = 8'h03;
  localparam logic [7:0] CMD_WRITE    = 8'h02;
  localparam int         ADDR_FIELD_W = 16;
  localparam int         DATA_W       = 16;
  localparam int         BIT_CNT_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_RDATA = 3'd3,
    ST_WDATA = 3'd4,
    ST_SKIP  = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_sram_responder_if.sv
`default_nettype none
// ============================================================================
// Module  : spi_sram_responder_if
// Purpose : Bundles the SPI pins, the backdoor load port and the status
//           pulses of the serial-SRAM responder.
// Ports   : master modport - drives SPI pins and backdoor, observes status
//           slave  modport - the responder side
// Revision: 1.0 - initial release
// ============================================================================
interface spi_sram_responder_if
  import spi_sram_responder_pkg::*;
#(
  parameter int ADDR_W = 10
);
  logic              spi_cs;
  logic              spi_sck;
  logic              spi_mosi;
  logic              spi_miso;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              busy;
  logic              wr_done;
  logic              cmd_err;

  modport master (
    output spi_cs, spi_sck, spi_mosi, ld_we, ld_addr, ld_data,
    input  spi_miso, busy, wr_done, cmd_err
  );

  modport slave (
    input  spi_cs, spi_sck, spi_mosi, ld_we, ld_addr, ld_data,
    output spi_miso, busy, wr_done, cmd_err
  );
endinterface
`default_nettype wire

// File: rtl/spi_sram_responder_edge_sync.sv
`default_nettype none
// ============================================================================
// Module  : spi_sram_responder_edge_sync
// Purpose : Optional synchroniser on the SPI pins plus single-cycle SCK
//           rise/fall and CS fall/rise pulses.
// Ports   : i_spi_cs/i_spi_sck/i_spi_mosi - raw pins
//           o_cs_s/o_mosi_s               - synchronised levels
//           o_sck_rise/o_sck_fall         - SCK edges, masked while CS high
//           o_cs_fall/o_cs_rise           - CS edges
// Revision: 1.0 - initial release
// ============================================================================
module spi_sram_responder_edge_sync #(
  parameter int SYNC_STAGES = 0
) (
  input  wire  clk,
  input  wire  rst,
  input  wire  i_spi_cs,
  input  wire  i_spi_sck,
  input  wire  i_spi_mosi,
  output logic o_cs_s,
  output logic o_mosi_s,
  output logic o_sck_rise,
  output logic o_sck_fall,
  output logic o_cs_fall,
  output logic o_cs_rise
);

  logic w_sck_s;
  logic r_sck_q;
  logic r_cs_q;

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign o_cs_s   = i_spi_cs;
      assign w_sck_s  = i_spi_sck;
      assign o_mosi_s = i_spi_mosi;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_cs_pipe;
      logic [SYNC_STAGES-1:0] r_sck_pipe;
      logic [SYNC_STAGES-1:0] r_mosi_pipe;

      // CS stages reset low so that a CS held low across reset is never
      // mistaken for a fresh falling edge.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cs_pipe   <= '0;
          r_sck_pipe  <= '0;
          r_mosi_pipe <= '0;
        end else begin
          r_cs_pipe[0]   <= i_spi_cs;
          r_sck_pipe[0]  <= i_spi_sck;
          r_mosi_pipe[0] <= i_spi_mosi;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            r_cs_pipe[i]   <= r_cs_pipe[i-1];
            r_sck_pipe[i]  <= r_sck_pipe[i-1];
            r_mosi_pipe[i] <= r_mosi_pipe[i-1];
          end
        end
      end

      assign o_cs_s   = r_cs_pipe[SYNC_STAGES-1];
      assign w_sck_s  = r_sck_pipe[SYNC_STAGES-1];
      assign o_mosi_s = r_mosi_pipe[SYNC_STAGES-1];
    end
  endgenerate

  // Delayed CS resets low for the same reason as the sync stages: after a
  // reset the target only arms on a CS rise followed by a CS fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sck_q <= 1'b0;
      r_cs_q  <= 1'b0;
    end else begin
      r_sck_q <= w_sck_s;
      r_cs_q  <= o_cs_s;
    end
  end

  assign o_sck_rise = w_sck_s & ~r_sck_q & ~o_cs_s;
  assign o_sck_fall = ~w_sck_s & r_sck_q & ~o_cs_s;
  assign o_cs_fall  = ~o_cs_s & r_cs_q;
  assign o_cs_rise  = o_cs_s & ~r_cs_q;

endmodule
`default_nettype wire

// File: rtl/spi_sram_responder.sv
`default_nettype none
// ============================================================================
// Module  : spi_sram_responder
// Purpose : SPI mode-0 target emulating a 23xx-style serial SRAM of 16-bit
//           words (READ 0x03 / WRITE 0x02, 16-bit address, streaming data)
//           with a backdoor load port for program preload.
// Ports   : clk, rst          - system clock, synchronous active-high reset
//           bus (slave)       - SPI pins, backdoor load, busy/wr_done/cmd_err
// Revision: 1.0 - initial release
// ============================================================================
module spi_sram_responder
  import spi_sram_responder_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int SYNC_STAGES = 0
) (
  input wire clk,
  input wire rst,
  spi_sram_responder_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Edge detection
  logic w_cs_s, w_mosi, w_rise, w_fall, w_cs_fall, w_cs_rise;

  spi_sram_responder_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk        (clk),
    .rst        (rst),
    .i_spi_cs   (bus.spi_cs),
    .i_spi_sck  (bus.spi_sck),
    .i_spi_mosi (bus.spi_mosi),
    .o_cs_s     (w_cs_s),
    .o_mosi_s   (w_mosi),
    .o_sck_rise (w_rise),
    .o_sck_fall (w_fall),
    .o_cs_fall  (w_cs_fall),
    .o_cs_rise  (w_cs_rise)
  );

  // Protocol state
  state_t                  r_state;
  logic [BIT_CNT_W-1:0]    r_bit_cnt;
  logic [ADDR_FIELD_W-2:0] r_shift;
  logic                    r_is_read;
  logic [ADDR_W-1:0]       r_addr;
  logic [DATA_W-1:0]       r_tx_sr;
  logic                    r_load;
  logic                    r_miso;
  logic                    r_busy;
  logic                    r_wr_done;
  logic                    r_cmd_err;

  // Pending SPI write that lost the write port to the backdoor
  logic                    r_pend_v;
  logic [ADDR_W-1:0]       r_pend_addr;
  logic [DATA_W-1:0]       r_pend_data;

  // Memory
  logic [DATA_W-1:0]       r_mem [DEPTH];
  logic [DATA_W-1:0]       r_rdata;

  logic [ADDR_FIELD_W-1:0] w_field;
  logic                    w_last_bit;
  logic                    w_spi_wr;
  logic                    w_re;
  logic [ADDR_W-1:0]       w_raddr;
  logic [DATA_W-1:0]       w_tx_src;
  logic                    w_mem_we;
  logic [ADDR_W-1:0]       w_waddr;
  logic [DATA_W-1:0]       w_wdata;
  logic                    w_commit;

  // Field including the bit arriving on this rise
  assign w_field    = {r_shift, w_mosi};
  assign w_last_bit = (r_bit_cnt == BIT_CNT_W'(15));
  assign w_spi_wr   = (r_state == ST_WDATA) && w_rise && w_last_bit;

  // Reads: the first word is fetched on the final address rise, later
  // words on the last fall of the previous word.
  assign w_re    = ((r_state == ST_ADDR) && w_rise && w_last_bit && r_is_read) ||
                   ((r_state == ST_RDATA) && w_fall && w_last_bit);
  assign w_raddr = (r_state == ST_ADDR) ? w_field[ADDR_W-1:0]
                                        : ADDR_W'(r_addr + 1'b1);

  // A fall may arrive in the same cycle the fetched word becomes valid.
  assign w_tx_src = r_load ? r_rdata : r_tx_sr;

  // Single write port: backdoor first, then a held SPI write, then a fresh one
  always_comb begin
    w_mem_we = 1'b0;
    w_waddr  = '0;
    w_wdata  = '0;
    w_commit = 1'b0;
    if (bus.ld_we) begin
      w_mem_we = 1'b1;
      w_waddr  = bus.ld_addr;
      w_wdata  = bus.ld_data;
    end else if (r_pend_v) begin
      w_mem_we = 1'b1;
      w_waddr  = r_pend_addr;
      w_wdata  = r_pend_data;
      w_commit = 1'b1;
    end else if (w_spi_wr) begin
      w_mem_we = 1'b1;
      w_waddr  = r_addr;
      w_wdata  = w_field;
      w_commit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
    if (w_re) begin
      r_rdata <= r_mem[w_raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_v    <= 1'b0;
      r_pend_addr <= '0;
      r_pend_data <= '0;
    end else if (w_spi_wr && (bus.ld_we || r_pend_v)) begin
      r_pend_v    <= 1'b1;
      r_pend_addr <= r_addr;
      r_pend_data <= w_field;
    end else if (!bus.ld_we) begin
      r_pend_v    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_is_read <= 1'b0;
      r_addr    <= '0;
      r_tx_sr   <= '0;
      r_load    <= 1'b0;
      r_miso    <= 1'b0;
      r_busy    <= 1'b0;
      r_wr_done <= 1'b0;
      r_cmd_err <= 1'b0;
    end else begin
      r_wr_done <= w_commit;
      r_cmd_err <= 1'b0;
      if (w_cs_rise) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
        r_miso  <= 1'b0;
        r_load  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_miso <= 1'b0;
            if (w_cs_fall) begin
              r_state   <= ST_CMD;
              r_bit_cnt <= '0;
              r_busy    <= 1'b1;
            end
          end
          ST_CMD: begin
            if (w_rise) begin
              r_shift   <= w_field[ADDR_FIELD_W-2:0];
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == BIT_CNT_W'(7)) begin
                r_bit_cnt <= '0;
                if (w_field[7:0] == CMD_READ) begin
                  r_is_read <= 1'b1;
                  r_state   <= ST_ADDR;
                end else if (w_field[7:0] == CMD_WRITE) begin
                  r_is_read <= 1'b0;
                  r_state   <= ST_ADDR;
                end else begin
                  r_cmd_err <= 1'b1;
                  r_state   <= ST_SKIP;
                end
              end
            end
          end
          ST_ADDR: begin
            if (w_rise) begin
              r_shift   <= w_field[ADDR_FIELD_W-2:0];
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (w_last_bit) begin
                r_addr  <= w_field[ADDR_W-1:0];
                r_state <= r_is_read ? ST_RDATA : ST_WDATA;
                r_load  <= r_is_read;
              end
            end
          end
          ST_RDATA: begin
            if (w_fall) begin
              r_miso    <= w_tx_src[DATA_W-1];
              r_tx_sr   <= {w_tx_src[DATA_W-2:0], 1'b0};
              r_load    <= 1'b0;
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (w_last_bit) begin
                r_addr <= ADDR_W'(r_addr + 1'b1);
                r_load <= 1'b1;
              end
            end else if (r_load) begin
              r_tx_sr <= r_rdata;
              r_load  <= 1'b0;
            end
          end
          ST_WDATA: begin
            if (w_rise) begin
              r_shift   <= w_field[ADDR_FIELD_W-2:0];
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (w_last_bit) begin
                r_addr <= ADDR_W'(r_addr + 1'b1);
              end
            end
          end
          ST_SKIP: begin
            r_miso <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_miso  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.spi_miso = r_miso;
  assign bus.busy     = r_busy;
  assign bus.wr_done  = r_wr_done;
  assign bus.cmd_err  = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_sram_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_sram_responder
// Purpose : Directed self-checking bench for spi_sram_responder.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_spi_sram_responder;

  localparam int ADDR_W = 10;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   wr_done_cnt;
  logic [15:0] rx;

  spi_sram_responder_if #(.ADDR_W(ADDR_W)) bus ();

  spi_sram_responder #(
    .ADDR_W      (ADDR_W),
    .SYNC_STAGES (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.wr_done === 1'b1) wr_done_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Shift n bits of v out MSB first; rx collects MISO sampled before each rise.
  task automatic spi_bits(input logic [15:0] v, input int n, output logic [15:0] r);
    r = '0;
    for (int i = n - 1; i >= 0; i--) begin
      bus.spi_mosi = v[i];
      tick(2);
      r = {r[14:0], bus.spi_miso};
      bus.spi_sck = 1'b1;
      tick(2);
      bus.spi_sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    bus.spi_cs = 1'b0;
    tick(2);
  endtask

  task automatic cs_high();
    bus.spi_cs = 1'b1;
    tick(3);
  endtask

  task automatic backdoor(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    bus.ld_we   = 1'b1;
    bus.ld_addr = a;
    bus.ld_data = d;
    tick(1);
    bus.ld_we   = 1'b0;
  endtask

  task automatic read_word(input logic [15:0] a, input string tag, input logic [15:0] exp);
    logic [15:0] r;
    cs_low();
    spi_bits(16'h0003, 8, r);
    spi_bits(a, 16, r);
    spi_bits(16'h0000, 16, r);
    check(tag, {16'h0, r}, {16'h0, exp});
    cs_high();
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    wr_done_cnt = 0;
    rst         = 1'b1;
    bus.spi_cs  = 1'b1;
    bus.spi_sck = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.ld_we   = 1'b0;
    bus.ld_addr = '0;
    bus.ld_data = '0;
    tick(3);
    check("reset_miso",    {31'h0, bus.spi_miso}, 32'h0);
    check("reset_busy",    {31'h0, bus.busy},     32'h0);
    check("reset_wr_done", {31'h0, bus.wr_done},  32'h0);
    check("reset_cmd_err", {31'h0, bus.cmd_err},  32'h0);
    rst = 1'b0;
    tick(2);

    // Basic read
    backdoor(10'h005, 16'hA5C3);
    cs_low();
    spi_bits(16'h0003, 8, rx);
    check("busy_mid_read", {31'h0, bus.busy}, 32'h1);
    spi_bits(16'h0005, 16, rx);
    spi_bits(16'h0000, 16, rx);
    check("read_005", {16'h0, rx}, 32'h0000_A5C3);
    cs_high();
    check("busy_after_read", {31'h0, bus.busy}, 32'h0);

    // Wrapping stream read
    backdoor(10'h3FF, 16'h1111);
    backdoor(10'h000, 16'h2222);
    cs_low();
    spi_bits(16'h0003, 8, rx);
    spi_bits(16'hFFFF, 16, rx);
    spi_bits(16'h0000, 16, rx);
    check("read_3ff", {16'h0, rx}, 32'h0000_1111);
    spi_bits(16'h0000, 16, rx);
    check("read_wrap_000", {16'h0, rx}, 32'h0000_2222);
    cs_high();

    // SPI write then read back
    wr_done_cnt = 0;
    cs_low();
    spi_bits(16'h0002, 8, rx);
    spi_bits(16'h0010, 16, rx);
    spi_bits(16'h1234, 16, rx);
    cs_high();
    check("write_wr_done_cnt", wr_done_cnt, 32'd1);
    read_word(16'h0010, "read_010", 16'h1234);

    // Partial write discarded
    backdoor(10'h020, 16'hBEEF);
    wr_done_cnt = 0;
    cs_low();
    spi_bits(16'h0002, 8, rx);
    spi_bits(16'h0020, 16, rx);
    spi_bits(16'h01FF, 9, rx);
    bus.spi_cs = 1'b1;
    tick(1);
    check("partial_busy_low", {31'h0, bus.busy}, 32'h0);
    tick(2);
    check("partial_no_wr_done", wr_done_cnt, 32'd0);
    read_word(16'h0020, "read_020", 16'hBEEF);

    // Unsupported opcode
    cs_low();
    spi_bits(16'h009F >> 1, 7, rx);
    bus.spi_mosi = 1'b1;
    tick(2);
    bus.spi_sck = 1'b1;
    tick(1);
    check("cmd_err_pulse", {31'h0, bus.cmd_err}, 32'h1);
    tick(1);
    check("cmd_err_one_cycle", {31'h0, bus.cmd_err}, 32'h0);
    bus.spi_sck = 1'b0;
    spi_bits(16'hFFFF, 16, rx);
    check("skip_miso_zero", {16'h0, rx}, 32'h0);
    cs_high();
    read_word(16'h0005, "read_after_err", 16'hA5C3);

    // Backdoor collides with the SPI write commit
    cs_low();
    spi_bits(16'h0002, 8, rx);
    spi_bits(16'h0031, 16, rx);
    spi_bits(16'h5678 >> 1, 15, rx);
    bus.spi_mosi = 1'b0;
    tick(2);
    bus.spi_sck = 1'b1;
    bus.ld_we   = 1'b1;
    bus.ld_addr = 10'h030;
    bus.ld_data = 16'h9ABC;
    tick(1);
    bus.ld_we = 1'b0;
    check("collide_wr_done_held", {31'h0, bus.wr_done}, 32'h0);
    tick(1);
    check("collide_wr_done_late", {31'h0, bus.wr_done}, 32'h1);
    bus.spi_sck = 1'b0;
    cs_high();
    cs_low();
    spi_bits(16'h0003, 8, rx);
    spi_bits(16'h0030, 16, rx);
    spi_bits(16'h0000, 16, rx);
    check("read_030_backdoor", {16'h0, rx}, 32'h0000_9ABC);
    spi_bits(16'h0000, 16, rx);
    check("read_031_spi", {16'h0, rx}, 32'h0000_5678);
    cs_high();

    // Reset in the middle of the address phase
    cs_low();
    spi_bits(16'h0003, 8, rx);
    spi_bits(16'h00AA, 8, rx);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("midrst_miso",    {31'h0, bus.spi_miso}, 32'h0);
    check("midrst_busy",    {31'h0, bus.busy},     32'h0);
    check("midrst_wr_done", {31'h0, bus.wr_done},  32'h0);
    check("midrst_cmd_err", {31'h0, bus.cmd_err},  32'h0);
    spi_bits(16'h0003, 8, rx);
    check("midrst_ignored_busy", {31'h0, bus.busy}, 32'h0);
    cs_high();
    read_word(16'h0005, "read_after_rst", 16'hA5C3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
